// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states, mode
// encodings and the default operand width.
package serial_add_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder used as the per-cycle step of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder step per cycle, LSB first,
// with registered sum, carry-out and signed overflow published on completion.
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned         CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]    LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state, next_state;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             mode_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic load;
  logic step;
  logic last;
  logic fa_b;
  logic fa_s;
  logic fa_cout;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = (cnt_q == LAST_BIT);
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Operands shift right so the active bit is always at position 0.
  assign fa_b = b_q[0] ^ (mode_q == MODE_SUB);

  full_adder u_full_adder (
    .a    (a_q[0]),
    .b    (fa_b),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      a_q     <= A;
      b_q     <= B;
      mode_q  <= mode;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
      carry_q <= fa_cout;
      cnt_q   <= cnt_q + CNT_W'(1);
      // carry_q still holds the carry into the MSB during the last step.
      if (last) begin
        S    <= {fa_s, sum_q[WIDTH-1:1]};
        cout <= fa_cout;
        ovf  <= carry_q ^ fa_cout;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
